// File: rtl/icache_nway.sv
// N-way set-associative instruction cache, round-robin replacement.
// Single-beat line refill, redirect kill and whole-cache flush.
module icache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   input  logic [ADDR_W-1:0]       req_addr_i,
   output logic                    req_ready_o,
   input  logic                    kill_i,
   input  logic                    flush_i,
   output logic                    flush_busy_o,
   output logic                    rsp_valid_o,
   output logic [31:0]             rsp_inst_o,
   output logic                    mem_req_valid_o,
   input  logic                    mem_req_ready_i,
   output logic [ADDR_W-1:0]       mem_req_addr_o,
   input  logic                    mem_rsp_valid_i,
   input  logic [32*LINE_WORDS-1:0] mem_rsp_data_i,
   output logic [31:0]             hit_cnt_o,
   output logic [31:0]             miss_cnt_o
);

   localparam int WW  = $clog2(LINE_WORDS);
   localparam int OFF = WW + 2;
   localparam int IW  = $clog2(SETS);
   localparam int TW  = ADDR_W - OFF - IW;
   localparam int PW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LW  = 32 * LINE_WORDS;

   typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, FLUSH} state_t;

   state_t          state;
   logic [WAYS-1:0] valid_q [SETS];
   logic [PW-1:0]   ptr_q   [SETS];
   logic [TW-1:0]   tag_q   [WAYS][SETS];
   logic [LW-1:0]   data_q  [WAYS][SETS];

   logic [TW-1:0] lat_tag;
   logic [IW-1:0] lat_idx;
   logic [IW-1:0] fidx;
   logic [WW-1:0] lat_woff;
   logic [PW-1:0] victim_q;
   logic          killed;
   logic          flush_pend;
   logic          ready_en;

   logic [TW-1:0] req_tag;
   logic [IW-1:0] req_idx;
   logic [WW-1:0] req_woff;
   logic          hit;
   logic [31:0]   hit_word;
   logic [PW-1:0] victim;
   logic          accept;
   logic          fill;

   assign req_tag  = req_addr_i[ADDR_W-1 -: TW];
   assign req_idx  = req_addr_i[OFF +: IW];
   assign req_woff = req_addr_i[2 +: WW];

   assign req_ready_o = ready_en && state == IDLE && !flush_i && !flush_pend;
   assign accept      = req_valid_i && req_ready_o;
   assign fill        = state == REFILL_WAIT && mem_rsp_valid_i;

   always_comb begin
      hit      = 1'b0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
            hit      = 1'b1;
            hit_word = data_q[w][req_idx][32*req_woff +: 32];
         end
      end
      // lowest invalid way wins, else the round-robin pointer
      victim = ptr_q[req_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) victim = PW'(w);
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[victim_q][lat_idx]  <= lat_tag;
         data_q[victim_q][lat_idx] <= mem_rsp_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         valid_q         <= '{default: '0};
         ptr_q           <= '{default: '0};
         lat_tag         <= '0;
         lat_idx         <= '0;
         lat_woff        <= '0;
         victim_q        <= '0;
         fidx            <= '0;
         killed          <= 1'b0;
         flush_pend      <= 1'b0;
         ready_en        <= 1'b0;
         flush_busy_o    <= 1'b0;
         rsp_valid_o     <= 1'b0;
         rsp_inst_o      <= '0;
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
         hit_cnt_o       <= '0;
         miss_cnt_o      <= '0;
      end else begin
         ready_en    <= 1'b1;
         rsp_valid_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush_i) begin
                  state        <= FLUSH;
                  flush_busy_o <= 1'b1;
                  fidx         <= '0;
               end else if (accept && hit) begin
                  rsp_valid_o <= 1'b1;
                  rsp_inst_o  <= hit_word;
                  hit_cnt_o   <= hit_cnt_o + 32'd1;
               end else if (accept) begin
                  lat_tag         <= req_tag;
                  lat_idx         <= req_idx;
                  lat_woff        <= req_woff;
                  victim_q        <= victim;
                  killed          <= 1'b0;
                  mem_req_valid_o <= 1'b1;
                  mem_req_addr_o  <= {req_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                  miss_cnt_o      <= miss_cnt_o + 32'd1;
                  state           <= REFILL_REQ;
                  if (WAYS > 1 && &valid_q[req_idx])
                     ptr_q[req_idx] <= ptr_q[req_idx] + PW'(1);
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_o <= 1'b0;
                  state           <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_rsp_valid_i) begin
                  valid_q[lat_idx][victim_q] <= 1'b1;
                  rsp_valid_o <= !(killed || kill_i);
                  rsp_inst_o  <= mem_rsp_data_i[32*lat_woff +: 32];
                  if (flush_pend || flush_i) begin
                     state        <= FLUSH;
                     flush_busy_o <= 1'b1;
                     fidx         <= '0;
                     flush_pend   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            FLUSH: begin
               valid_q[fidx] <= '0;
               ptr_q[fidx]   <= '0;
               fidx          <= fidx + IW'(1);
               if (fidx == IW'(SETS - 1)) begin
                  state        <= IDLE;
                  flush_busy_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         if (state == REFILL_REQ || (state == REFILL_WAIT && !mem_rsp_valid_i)) begin
            if (kill_i)  killed     <= 1'b1;
            if (flush_i) flush_pend <= 1'b1;
         end
      end
   end

endmodule
